mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter downstream of the pipelined core: merges the IF-stage instruction fetch and the MEM-stage load/store onto one synchronous single-port RAM. It replaces clock-phase time-multiplexing with an explicit request/grant handshake, generates byte enables and store-data replication for byte/half/word stores, and tags each read response to its requester.

## Interface
Parameters:
- AW, 12, byte-address width of both request ports; memory word address is AW-2 bits.
- MAX_STARVE, 4, consecutive denied fetch cycles after which fetch wins one arbitration.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until granted.
- if_addr  in  AW  fetch byte address; bits [1:0] are ignored.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  instruction word.
- d_req  in  1  data request, held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- d_addr  in  AW  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  raw aligned memory word; extension is done by the core.
- d_misalign  out  1  misaligned data access; pulses with d_gnt.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write.
- m_be  out  4  byte enables.
- m_addr  out  AW-2  word address.
- m_wdata  out  32  lane-replicated store data.
- m_rdata  in  32  memory read data, valid one cycle after a read enable.

## Operation
- Arbitration is combinational each cycle from the requests and the registered starvation state. Only one grant is issued per cycle.
- Data has priority over fetch because it belongs to the older instruction.
- Fetch wins when starve_cnt == MAX_STARVE and both requests are present.
- starve_cnt:
  - increments (saturating) each cycle in which if_req=1 and if_gnt=0;
  - clears on if_gnt;
  - width is clog2(MAX_STARVE+1).
- Grant drives m_en=1, m_addr=addr[AW-1:2], and m_we=d_we for data (0 for fetch).
- Byte enables and store data:
  - byte: m_be = 1<<addr[1:0]; wdata[7:0] replicated ×4.
  - half: m_be = 0011 if addr[1]=0, else 1100; wdata[15:0] replicated ×2.
  - word: m_be = 1111.
  - Reads drive m_be = 1111.
- Misaligned access is half with addr[0]=1, or word with addr[1:0]≠0:
  - d_gnt=1 and d_misalign=1; m_en stays 0.
  - A load still gets d_rvalid the next cycle with d_rdata=0, so the pipeline never hangs.
- Response tracking uses a registered pend_valid/pend_src pair, set on a granted read (including a misaligned load).
  - Next cycle: the matching rvalid=1 and rdata=m_rdata (0 if misaligned).
  - The non-matching rvalid is 0; if_rdata/d_rdata hold their last value.
- Stores produce no rvalid.
- Back-to-back grants are allowed every cycle; a new grant and a previous response coexist.

## Timing
- Grant latency is 0 cycles: gnt is in the same cycle as a held req.
- Read latency is exactly 1 cycle from gnt to rvalid.
- Throughput is 1 access per cycle total.
- While rst=0:
  - all outputs are 0;
  - pend_valid=0 and starve_cnt=0;
  - grants are forced to 0.
- Reset mid-operation: an outstanding read is dropped; no rvalid appears after release.
- First grant is possible in the first cycle with rst=1.
- Simultaneous requests: data is granted and fetch is denied (starve_cnt+1), unless the starvation threshold is reached.
- Requests with gnt=0 must keep their address and data stable. The arbiter does not register them.

## Structure
- Package mem_arb_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - source enum SRC_IF/SRC_D;
  - a misalignment helper function.
- Sub-module mem_store_align: combinational (d_size, addr[1:0], d_wdata) → (m_be, m_wdata, misalign).
- Top-level mem_arbiter contains the arbitration, starvation counter and response tracker.

## Test plan
- Fetch only at addresses 0x000, 0x004, 0x008, with m_rdata = address+0x100 → if_gnt each cycle; if_rvalid one cycle later with if_rdata 0x100, 0x104, 0x108; d_rvalid stays 0.
- if_req and d_req (load at 0x010) held together → data granted first, then fetch; with MAX_STARVE=4 and d_req held continuously, the fetch grant comes on the 5th cycle.
- Store byte 0xA5 at 0x013 → m_be=1000, m_wdata=0xA5A5A5A5, m_we=1, no d_rvalid; half 0xBEEF at 0x012 → m_be=1100, m_wdata=0xBEEFBEEF.
- Word load at 0x006 → d_gnt=1, d_misalign=1, m_en=0; next cycle d_rvalid=1, d_rdata=0.
- Read granted, then rst driven low before the response edge → no rvalid; all outputs 0; after release, the first request is granted in the first cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the single-port memory arbiter.
// Access sizes, requester tags and the misalignment rule live here.
package mem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_e;

  // Size 2'b11 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lsb[0];
      default: mis = (lsb != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] replicate_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_store_align.sv
// Combinational byte-enable, store-lane and misalignment generation
// for data-port accesses.
module mem_store_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lsb,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic        misalign
);

  // Byte enables by access size and low address bits.
  always_comb begin
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << lsb;
      SZ_HALF: begin
        if (lsb[1]) begin
          be = 4'b1100;
        end else begin
          be = 4'b0011;
        end
      end
      default: be = 4'b1111;
    endcase
  end

  assign lane_wdata = replicate_lanes(size, wdata);
  assign misalign   = is_misaligned(size, lsb);

endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction fetch and data load/store onto one single-port RAM
// with data priority, fetch anti-starvation and tagged read responses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 12,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_misalign,
  output logic          m_en,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-3:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(MAX_STARVE);

  logic [SW-1:0] starve_cnt_r;
  logic          pend_valid_r;
  src_e          pend_src_r;
  logic          pend_mis_r;
  logic [31:0]   if_rdata_r;
  logic [31:0]   d_rdata_r;

  logic          if_gnt_s;
  logic          d_gnt_s;
  logic [3:0]    st_be_s;
  logic [31:0]   st_wdata_s;
  logic          st_mis_s;
  logic          if_rsp_s;
  logic          d_rsp_s;
  logic [31:0]   d_rsp_data_s;
  logic          unused_s;

  assign unused_s = ^if_addr[1:0];

  mem_store_align u_align (
    .size       (d_size),
    .lsb        (d_addr[1:0]),
    .wdata      (d_wdata),
    .be         (st_be_s),
    .lane_wdata (st_wdata_s),
    .misalign   (st_mis_s)
  );

  // Data wins unless fetch has been denied MAX_STARVE cycles in a row.
  always_comb begin
    if_gnt_s = 1'b0;
    d_gnt_s  = 1'b0;
    if (!rst) begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end else if (d_req && !(if_req && (starve_cnt_r == STARVE_LIMIT))) begin
      d_gnt_s = 1'b1;
    end else if (if_req) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end
  end

  // Memory port drive; a misaligned data access is acknowledged without touching the RAM.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_be    = 4'b0000;
    m_addr  = {(AW-2){1'b0}};
    m_wdata = 32'h0000_0000;
    if (if_gnt_s) begin
      m_en   = 1'b1;
      m_be   = 4'b1111;
      m_addr = if_addr[AW-1:2];
    end else if (d_gnt_s && !st_mis_s) begin
      m_en   = 1'b1;
      m_we   = d_we;
      m_addr = d_addr[AW-1:2];
      if (d_we) begin
        m_be    = st_be_s;
        m_wdata = st_wdata_s;
      end else begin
        m_be    = 4'b1111;
        m_wdata = 32'h0000_0000;
      end
    end else begin
      m_en = 1'b0;
    end
  end

  assign if_gnt     = if_gnt_s;
  assign d_gnt      = d_gnt_s;
  assign d_misalign = d_gnt_s & st_mis_s;

  // Consecutive-denial counter for the fetch port, saturating at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (if_gnt_s) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (if_req && (starve_cnt_r != STARVE_LIMIT)) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // One outstanding read at most: its source and whether it was a misaligned load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_r <= 1'b0;
      pend_src_r   <= SRC_IF;
      pend_mis_r   <= 1'b0;
    end else begin
      pend_valid_r <= if_gnt_s | (d_gnt_s & ~d_we);
      pend_src_r   <= d_gnt_s ? SRC_D : SRC_IF;
      pend_mis_r   <= d_gnt_s & st_mis_s;
    end
  end

  assign if_rsp_s     = pend_valid_r && (pend_src_r == SRC_IF);
  assign d_rsp_s      = pend_valid_r && (pend_src_r == SRC_D);
  assign d_rsp_data_s = pend_mis_r ? 32'h0000_0000 : m_rdata;

  // Capture delivered read data so each port holds its last response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_r <= 32'h0000_0000;
      d_rdata_r  <= 32'h0000_0000;
    end else begin
      if (if_rsp_s) begin
        if_rdata_r <= m_rdata;
      end
      if (d_rsp_s) begin
        d_rdata_r <= d_rsp_data_s;
      end
    end
  end

  assign if_rvalid = if_rsp_s;
  assign if_rdata  = if_rsp_s ? m_rdata : if_rdata_r;
  assign d_rvalid  = d_rsp_s;
  assign d_rdata   = d_rsp_s ? d_rsp_data_s : d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: a byte-level reference memory
// predicts read data, a separate monitor checks responses from a scoreboard.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int MAX_STARVE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_misalign;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic          m_en, m_we;
  logic [3:0]    m_be;
  logic [AW-3:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;

  mem_arbiter #(.AW(AW), .MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_misalign(d_misalign),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int starve = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bench RAM: unwritten words read as 0x100 + byte address.
  bit [31:0] ram [1024];
  bit        ram_wr [1024];
  always @(posedge clk) begin : ram_model
    logic [31:0] cur;
    if (m_en) begin
      cur = ram_wr[m_addr] ? ram[m_addr] : (32'h100 + {20'h0, m_addr, 2'b00});
      if (m_we) begin
        for (int i = 0; i < 4; i++) if (m_be[i]) cur[8*i +: 8] = m_wdata[8*i +: 8];
        ram[m_addr]    <= cur;
        ram_wr[m_addr] <= 1'b1;
      end else begin
        m_rdata <= cur;
      end
    end
  end

  logic [7:0] ref_mem [4096];

  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t q_if[$];
  exp_t q_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_word(input logic [11:0] ad);
    int w;
    w = {20'h0, ad[11:2], 2'b00};
    return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
  endfunction

  // One cycle: drive requests, check grants/memory port against the rules, queue expected reads.
  task automatic step(input logic ireq, input logic [11:0] iaddr, input logic dreq, input logic dwe,
                      input logic [1:0] dsz, input logic [11:0] daddr, input logic [31:0] dwd,
                      output logic ig, output logic dg);
    logic mis, men;
    logic [3:0] be;
    logic [31:0] wd;
    int a;
    @(negedge clk);
    if_req = ireq; if_addr = iaddr;
    d_req = dreq; d_we = dwe; d_size = dsz; d_addr = daddr; d_wdata = dwd;
    #1;
    dg  = dreq && !(ireq && starve == MAX_STARVE);
    ig  = ireq && !dg;
    mis = dg && ((dsz == 2'b01 && daddr[0]) || (dsz[1] && daddr[1:0] != 2'b00));
    men = ig || (dg && !mis);
    chk("if_gnt", if_gnt, ig);
    chk("d_gnt", d_gnt, dg);
    chk("d_misalign", d_misalign, mis);
    chk("m_en", m_en, men);
    if (men) begin
      chk("m_we", m_we, dg && dwe);
      chk("m_addr", m_addr, ig ? (iaddr >> 2) : (daddr >> 2));
      if (dg && dwe) begin
        a = daddr;
        if (dsz == 2'b00) begin
          be = 4'b0001 << daddr[1:0]; wd = {4{dwd[7:0]}};
          ref_mem[a] = dwd[7:0];
        end else if (dsz == 2'b01) begin
          be = daddr[1] ? 4'b1100 : 4'b0011; wd = {2{dwd[15:0]}};
          ref_mem[a] = dwd[7:0]; ref_mem[a+1] = dwd[15:8];
        end else begin
          be = 4'b1111; wd = dwd;
          for (int k = 0; k < 4; k++) ref_mem[a+k] = dwd[8*k +: 8];
        end
        chk("m_be", m_be, be);
        chk("m_wdata", m_wdata, wd);
      end else begin
        chk("m_be_read", m_be, 4'b1111);
      end
    end
    if (ig) q_if.push_back('{cyc + 1, ref_word(iaddr)});
    if (dg && !dwe) q_d.push_back('{cyc + 1, mis ? 32'h0 : ref_word(daddr)});
    if (ig) starve = 0;
    else if (ireq && starve < MAX_STARVE) starve = starve + 1;
  endtask

  // Monitor: every cycle, rvalid must match the scoreboard head and rdata must hold otherwise.
  always begin : monitor
    logic ev;
    logic [31:0] last_if, last_d;
    @(negedge clk);
    #2;
    if (!rst) begin
      last_if = 32'h0; last_d = 32'h0;
    end
    ev = (q_if.size() > 0) && (q_if[0].due == cyc);
    chk("if_rvalid", if_rvalid, ev);
    if (ev) begin
      chk("if_rdata", if_rdata, q_if[0].data);
      last_if = q_if[0].data;
      void'(q_if.pop_front());
    end else begin
      chk("if_rdata_hold", if_rdata, last_if);
    end
    ev = (q_d.size() > 0) && (q_d[0].due == cyc);
    chk("d_rvalid", d_rvalid, ev);
    if (ev) begin
      chk("d_rdata", d_rdata, q_d[0].data);
      last_d = q_d[0].data;
      void'(q_d.pop_front());
    end else begin
      chk("d_rdata_hold", d_rdata, last_d);
    end
  end

  function automatic logic any_output();
    return |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_misalign,
             m_en, m_we, m_be, m_addr, m_wdata};
  endfunction

  initial begin
    logic ig, dg;
    logic h_ireq, h_dreq, h_dwe;
    logic [11:0] h_iaddr, h_daddr;
    logic [1:0] h_dsz;
    logic [31:0] h_dwd;
    logic [31:0] w;

    rst = 1'b0;
    if_req = 1'b0; if_addr = 12'h0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = 12'h0; d_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      w = 32'h100 + i * 4;
      for (int k = 0; k < 4; k++) ref_mem[i*4+k] = w[8*k +: 8];
    end

    // Reset: outputs zero and grants suppressed even with both requests up.
    @(negedge clk);
    if_req = 1'b1; d_req = 1'b1;
    #1;
    chk("reset_outputs_zero", any_output(), 1'b0);
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1; rst = 1'b1;

    // Fetch-only stream in the first cycles after release.
    step(1'b1, 12'h000, 1'b0, 1'b0, 2'b10, 12'h0, 32'h0, ig, dg);
    chk("first_cycle_fetch_gnt", if_gnt, 1'b1);
    step(1'b1, 12'h004, 1'b0, 1'b0, 2'b10, 12'h0, 32'h0, ig, dg);
    step(1'b1, 12'h008, 1'b0, 1'b0, 2'b10, 12'h0, 32'h0, ig, dg);
    step(1'b0, 12'h000, 1'b0, 1'b0, 2'b10, 12'h0, 32'h0, ig, dg);

    // Both held: data wins four times, fetch on the fifth.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 12'h040, 1'b1, 1'b0, 2'b10, 12'h010, 32'h0, ig, dg);
      chk("starve_fetch_turn", if_gnt, (k == 4));
    end

    // Byte and half stores, then read the word back.
    step(1'b0, 12'h0, 1'b1, 1'b1, 2'b00, 12'h013, 32'h0000_00A5, ig, dg);
    chk("store_byte_be", m_be, 4'b1000);
    chk("store_byte_wdata", m_wdata, 32'hA5A5_A5A5);
    step(1'b0, 12'h0, 1'b1, 1'b1, 2'b01, 12'h012, 32'h0000_BEEF, ig, dg);
    chk("store_half_be", m_be, 4'b1100);
    chk("store_half_wdata", m_wdata, 32'hBEEF_BEEF);
    step(1'b0, 12'h0, 1'b1, 1'b0, 2'b10, 12'h010, 32'h0, ig, dg);

    // Misaligned word load: acknowledged, no RAM access, zero data next cycle.
    step(1'b0, 12'h0, 1'b1, 1'b0, 2'b10, 12'h006, 32'h0, ig, dg);
    chk("misalign_flag", d_misalign, 1'b1);
    chk("misalign_no_men", m_en, 1'b0);
    step(1'b0, 12'h0, 1'b0, 1'b0, 2'b10, 12'h0, 32'h0, ig, dg);

    // Randomized traffic honouring hold-until-granted.
    h_ireq = 1'b0; h_dreq = 1'b0; h_dwe = 1'b0;
    h_iaddr = 12'h0; h_daddr = 12'h0; h_dsz = 2'b00; h_dwd = 32'h0;
    repeat (400) begin
      if (!h_ireq) begin
        h_ireq  = ($urandom_range(0, 3) != 0);
        h_iaddr = 12'($urandom_range(0, 63));
      end
      if (!h_dreq) begin
        h_dreq  = ($urandom_range(0, 2) != 0);
        h_dwe   = 1'($urandom_range(0, 1));
        h_dsz   = 2'($urandom_range(0, 3));
        h_daddr = 12'($urandom_range(0, 63));
        h_dwd   = $urandom;
      end
      step(h_ireq, h_iaddr, h_dreq, h_dwe, h_dsz, h_daddr, h_dwd, ig, dg);
      if (ig) h_ireq = 1'b0;
      if (dg) h_dreq = 1'b0;
    end

    // Reset while a read is outstanding: the response is dropped.
    step(1'b1, 12'h020, 1'b0, 1'b0, 2'b10, 12'h0, 32'h0, ig, dg);
    #2;
    rst = 1'b0;
    q_if.delete(); q_d.delete(); starve = 0;
    repeat (2) begin
      @(negedge clk);
      if_req = 1'b1; d_req = 1'b1;
      #1;
      chk("midreset_outputs_zero", any_output(), 1'b0);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    step(1'b0, 12'h0, 1'b1, 1'b0, 2'b10, 12'h010, 32'h0, ig, dg);
    chk("post_reset_first_gnt", d_gnt, 1'b1);

    repeat (3) step(1'b0, 12'h0, 1'b0, 1'b0, 2'b10, 12'h0, 32'h0, ig, dg);
    @(negedge clk); #3;
    chk("scoreboard_drained", q_if.size() + q_d.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
